mux_rr_nx1: RTL and testbench

- Parametrised successor to the 32-bit 2x1 datapath mux: an N-input, W-bit multiplexer with a registered output.
- Uses valid/ready handshakes and picks the source channel by round-robin arbitration instead of a static select.
- Sits between multiple producers (register-file read ports, ALU result, memory data) and one consumer.
- 1-cycle latency, one transfer per cycle sustained.

---
 rtl/mux_rr_nx1_pkg.sv | 13 +
 rtl/mux_rr_nx1_rr_pick.sv | 30 +++
 rtl/mux_rr_nx1.sv | 103 ++++++++++
 tb/tb_mux_rr_nx1.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mux_rr_nx1_pkg.sv
// Shared constants and helpers for the round-robin N-to-1 output mux.
// Optional build macro MUX_FORCE_SEL_EN is consumed by mux_rr_nx1 only.
package mux_rr_nx1_pkg;

  localparam int DATA_WIDTH       = 32;
  localparam int DATA_INDEX_LIMIT = DATA_WIDTH - 1;

  // Channel-index width; a single channel still needs a 1-bit index port.
  function automatic int clog2_min1(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/mux_rr_nx1_rr_pick.sv
// Combinational round-robin picker: first set request at or after ptr, wrapping at N_CH.
module rr_pick
  import mux_rr_nx1_pkg::*;
#(
  parameter int N_CH  = 4,
  parameter int SEL_W = clog2_min1(N_CH)
) (
  input  logic [N_CH-1:0]  req,
  input  logic [SEL_W-1:0] ptr,
  output logic [SEL_W-1:0] grant,
  output logic             found
);

  int cand;

  always_comb begin
    // NOTE: every output gets a default before the loop, so no path leaves it unassigned (no latch).
    grant = '0;
    found = 1'b0;
    cand  = 0;
    for (int i = 0; i < N_CH; i++) begin
      cand = (int'(ptr) + i) % N_CH;
      if (!found && req[cand]) begin
        found = 1'b1;
        grant = SEL_W'(cand);
      end
    end
  end

endmodule

// File: rtl/mux_rr_nx1.sv
// N-input, W-bit valid/ready mux with round-robin arbitration and a registered output.
// Build macro MUX_FORCE_SEL_EN adds FSEL_VALID/FSEL for classic static-select override.
module mux_rr_nx1
  import mux_rr_nx1_pkg::*;
#(
  parameter int N_CH   = 4,
  parameter int DATA_W = DATA_WIDTH,
  parameter int SEL_W  = clog2_min1(N_CH)
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic [N_CH*DATA_W-1:0]   I_DATA,
  input  logic [N_CH-1:0]          I_VALID,
  output logic [N_CH-1:0]          I_READY,
  output logic [DATA_W-1:0]        Y,
  output logic                     Y_VALID,
  input  logic                     Y_READY,
  output logic [SEL_W-1:0]         Y_SEL
`ifdef MUX_FORCE_SEL_EN
  ,
  input  logic                     FSEL_VALID,
  input  logic [SEL_W-1:0]         FSEL
`endif
);

  logic [SEL_W-1:0]  ptr;
  logic [SEL_W-1:0]  rr_grant;
  logic              rr_found;
  logic [SEL_W-1:0]  grant;
  logic              found;
  logic              advance;
  logic              load_en;
  logic              take;
  logic [DATA_W-1:0] sel_data;

  rr_pick #(
    .N_CH  (N_CH),
    .SEL_W (SEL_W)
  ) u_rr_pick (
    .req   (I_VALID),
    .ptr   (ptr),
    .grant (rr_grant),
    .found (rr_found)
  );

`ifdef MUX_FORCE_SEL_EN
  // A forced index outside 0..N_CH-1 matches no channel and so grants nothing.
  always_comb begin
    grant   = rr_grant;
    found   = rr_found;
    advance = 1'b1;
    if (FSEL_VALID) begin
      grant   = FSEL;
      found   = 1'b0;
      advance = 1'b0;
      for (int k = 0; k < N_CH; k++) begin
        if (FSEL == SEL_W'(k)) found = I_VALID[k];
      end
    end
  end
`else
  assign grant   = rr_grant;
  assign found   = rr_found;
  assign advance = 1'b1;
`endif

  // Output register is free when empty or being drained this cycle.
  assign load_en = !Y_VALID || Y_READY;
  assign take    = load_en && found;

  always_comb begin
    sel_data = '0;
    I_READY  = '0;
    for (int k = 0; k < N_CH; k++) begin
      if (grant == SEL_W'(k)) begin
        sel_data   = I_DATA[k*DATA_W +: DATA_W];
        I_READY[k] = take && RST;
      end
    end
  end

  // NOTE: sequential state is updated with non-blocking assignments only.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      ptr     <= '0;
      Y       <= '0;
      Y_SEL   <= '0;
      Y_VALID <= 1'b0;
    end else if (load_en) begin
      if (found) begin
        Y       <= sel_data;
        Y_SEL   <= grant;
        Y_VALID <= 1'b1;
        if (advance) begin
          ptr <= (grant == SEL_W'(N_CH - 1)) ? '0 : grant + SEL_W'(1);
        end
      end else begin
        Y_VALID <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_mux_rr_nx1.sv
// Self-checking bench for mux_rr_nx1: a 4-channel and a 3-channel instance share stimulus.
module tb_mux_rr_nx1;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [127:0] in_data = '0;
  logic [3:0]   in_valid = '0;
  logic         y_ready = 1'b0;
  logic         fsel_valid = 1'b0;
  logic [1:0]   fsel = '0;

  logic [3:0]   ready4;
  logic [31:0]  y4;
  logic         yv4;
  logic [1:0]   sel4;
  logic [2:0]   ready3;
  logic [31:0]  y3;
  logic         yv3;
  logic [1:0]   sel3;

  int total = 0;
  int bad   = 0;

  // Reference state: index 0 models the 4-channel instance, index 1 the 3-channel one.
  int          m_ptr[2];
  int          m_sel[2];
  logic        m_valid[2];
  logic [31:0] m_y[2];

  always #5 clk = ~clk;

  mux_rr_nx1 #(.N_CH(4), .DATA_W(32)) dut4 (
    .CLK        (clk),
    .RST        (rst_n),
    .I_DATA     (in_data),
    .I_VALID    (in_valid),
    .I_READY    (ready4),
    .Y          (y4),
    .Y_VALID    (yv4),
    .Y_READY    (y_ready),
    .Y_SEL      (sel4)
`ifdef MUX_FORCE_SEL_EN
    ,
    .FSEL_VALID (fsel_valid),
    .FSEL       (fsel)
`endif
  );

  mux_rr_nx1 #(.N_CH(3), .DATA_W(32)) dut3 (
    .CLK        (clk),
    .RST        (rst_n),
    .I_DATA     (in_data[95:0]),
    .I_VALID    (in_valid[2:0]),
    .I_READY    (ready3),
    .Y          (y3),
    .Y_VALID    (yv3),
    .Y_READY    (y_ready),
    .Y_SEL      (sel3)
`ifdef MUX_FORCE_SEL_EN
    ,
    .FSEL_VALID (1'b0),
    .FSEL       (2'b00)
`endif
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [3:0] chan_mask(input int n);
    return (n == 4) ? 4'b1111 : 4'b0111;
  endfunction

  // Channel the spec's rules would grant, or -1 when none.
  function automatic int pick(input int id, input int n);
    logic [3:0] v;
    v = in_valid & chan_mask(n);
    if (id == 0 && fsel_valid) return (int'(fsel) < n && v[fsel]) ? int'(fsel) : -1;
    for (int i = 0; i < n; i++) begin
      if (v[(m_ptr[id] + i) % n]) return (m_ptr[id] + i) % n;
    end
    return -1;
  endfunction

  function automatic logic [3:0] exp_ready(input int id, input int n);
    int g;
    g = pick(id, n);
    if (!rst_n || (m_valid[id] && !y_ready) || g < 0) return 4'b0000;
    return 4'b0001 << g;
  endfunction

  task automatic model_reset();
    for (int id = 0; id < 2; id++) begin
      m_ptr[id] = 0; m_sel[id] = 0; m_valid[id] = 1'b0; m_y[id] = '0;
    end
  endtask

  task automatic model_edge(input int id, input int n);
    int g;
    g = pick(id, n);
    if (!m_valid[id] || y_ready) begin
      if (g >= 0) begin
        m_y[id]     = in_data[g*32 +: 32];
        m_sel[id]   = g;
        m_valid[id] = 1'b1;
        if (!(id == 0 && fsel_valid)) m_ptr[id] = (g + 1) % n;
      end else begin
        m_valid[id] = 1'b0;
      end
    end
  endtask

  task automatic check_ready();
    #1;
    check("ready4", ready4, exp_ready(0, 4));
    check("ready3", ready3, exp_ready(1, 3));
  endtask

  task automatic clock_edge();
    @(posedge clk);
    model_edge(0, 4);
    model_edge(1, 3);
    #1;
    check("y4",   y4,   m_y[0]);
    check("yv4",  yv4,  m_valid[0]);
    check("sel4", sel4, m_sel[0]);
    check("y3",   y3,   m_y[1]);
    check("yv3",  yv3,  m_valid[1]);
    check("sel3", sel3, m_sel[1]);
  endtask

  int fair4[5] = '{0, 1, 2, 3, 0};
  int fair3[5] = '{0, 1, 2, 0, 1};

  initial begin
    model_reset();
    in_valid = 4'b1111;
    #2;
    check("rst_y",     y4,     32'h0);
    check("rst_yv",    yv4,    1'b0);
    check("rst_sel",   sel4,   2'd0);
    check("rst_ready", ready4, 4'b0000);
    @(posedge clk); #1;
    rst_n = 1'b1;
    in_valid = '0;

    // Single request on channel 2.
    in_data[2*32 +: 32] = 32'h1234_5678;
    in_valid = 4'b0100;
    y_ready = 1'b1;
    check_ready();
    check("single_ready", ready4, 4'b0100);
    clock_edge();
    check("single_y",   y4,   32'h1234_5678);
    check("single_sel", sel4, 2'd2);

    // Reset mid-transfer, between clock edges.
    in_data[31:0] = 32'hABCD_0000;
    in_valid = 4'b0001;
    check_ready();
    clock_edge();
    check("pre_rst_y", y4, 32'hABCD_0000);
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check("mid_rst_y",     y4,     32'h0);
    check("mid_rst_yv",    yv4,    1'b0);
    check("mid_rst_sel",   sel4,   2'd0);
    check("mid_rst_ready", ready4, 4'b0000);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Fairness with all channels valid; the 3-channel copy exercises the wrap.
    for (int k = 0; k < 4; k++) in_data[k*32 +: 32] = 32'h1111_0000 + k;
    in_valid = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      check_ready();
      clock_edge();
      check("fair_sel4", sel4, fair4[i]);
      check("fair_y4",   y4,   32'h1111_0000 + fair4[i]);
      check("wrap_sel3", sel3, fair3[i]);
    end

    // Backpressure for three cycles, then resume with no bubble.
    y_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check_ready();
      check("bp_ready", ready4, 4'b0000);
      clock_edge();
      check("bp_sel", sel4, 2'd0);
      check("bp_y",   y4,   32'h1111_0000);
    end
    y_ready = 1'b1;
    check_ready();
    check("resume_ready", ready4, 4'b0010);
    clock_edge();
    check("resume_sel", sel4, 2'd1);
    check("resume_yv",  yv4,  1'b1);

`ifdef MUX_FORCE_SEL_EN
    fsel_valid = 1'b1;
    fsel = 2'd3;
    in_valid = 4'b1001;
    for (int i = 0; i < 3; i++) begin
      check_ready();
      check("force_ready", ready4, 4'b1000);
      clock_edge();
      check("force_sel", sel4, 2'd3);
    end
    fsel_valid = 1'b0;
    in_valid = 4'b1111;
    check_ready();
    check("force_ptr_kept", ready4, 4'b0100);
    clock_edge();
    fsel_valid = 1'b1;
    fsel = 2'd1;
    in_valid = 4'b1001;
    check_ready();
    check("force_none_ready", ready4, 4'b0000);
    clock_edge();
    check("force_drain_yv", yv4, 1'b0);
    fsel_valid = 1'b0;
`endif

    // Randomized traffic against the reference model.
    for (int i = 0; i < 400; i++) begin
      in_valid = 4'($urandom);
      for (int k = 0; k < 4; k++) in_data[k*32 +: 32] = $urandom;
      y_ready = ($urandom_range(0, 3) != 0);
`ifdef MUX_FORCE_SEL_EN
      fsel_valid = ($urandom_range(0, 4) == 0);
      fsel = 2'($urandom);
`endif
      check_ready();
      clock_edge();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
